// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the MEM-stage load/store
// path (P) and a debug/DMA port (D). P has fixed priority by default; define
// DMEM_ARB_FAIR_EN to alternate the grant on simultaneous requests.
module dmem_arbiter #(
   parameter int unsigned AW = 32,
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          p_read,
   input  logic          p_write,
   input  logic [AW-1:0] p_addr,
   input  logic [DW-1:0] p_wdata,
   output logic [DW-1:0] p_rdata,
   output logic          stall,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic [DW-1:0] d_rdata,
   output logic          d_ack,
   output logic          m_req,
   output logic          m_we,
   output logic [AW-1:0] m_addr,
   output logic [DW-1:0] m_wdata,
   input  logic [DW-1:0] m_rdata,
   input  logic          m_ready
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      P_BUSY = 3'd1,
      P_DONE = 3'd2,
      D_BUSY = 3'd3,
      D_DONE = 3'd4
   } state_e;

   state_e        state_q, state_d;
   logic          m_req_q, m_req_d;
   logic          m_we_q, m_we_d;
   logic [AW-1:0] m_addr_q, m_addr_d;
   logic [DW-1:0] m_wdata_q, m_wdata_d;
   logic [DW-1:0] p_rdata_q, p_rdata_d;
   logic [DW-1:0] d_rdata_q, d_rdata_d;
   logic          d_ack_q, d_ack_d;

   logic          p_pend;
   logic          grant_p;

   assign p_pend = p_read | p_write;

`ifdef DMEM_ARB_FAIR_EN
   // last_d_q = 1 when the most recent grant went to D (reset value: D)
   logic last_d_q, last_d_d;

   // On a tie, P wins only if D was granted last
   assign grant_p = p_pend && (!d_req || last_d_q);

   // Record which port receives each new grant
   always_comb begin
      last_d_d = last_d_q;
      if ((state_q == IDLE) && (p_pend || d_req)) begin
         last_d_d = !grant_p;
      end
   end

   // Last-grant flag register
   always_ff @(posedge clk) begin
      if (reset) begin
         last_d_q <= 1'b1;
      end else begin
         last_d_q <= last_d_d;
      end
   end
`else
   // Fixed priority: any P request beats D
   assign grant_p = p_pend;
`endif

   // Next-state and registered-output logic
   always_comb begin
      state_d   = state_q;
      m_req_d   = m_req_q;
      m_we_d    = m_we_q;
      m_addr_d  = m_addr_q;
      m_wdata_d = m_wdata_q;
      p_rdata_d = p_rdata_q;
      d_rdata_d = d_rdata_q;
      d_ack_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant_p) begin
               state_d   = P_BUSY;
               m_req_d   = 1'b1;
               m_we_d    = p_write;
               m_addr_d  = p_addr;
               m_wdata_d = p_wdata;
            end else if (d_req) begin
               state_d   = D_BUSY;
               m_req_d   = 1'b1;
               m_we_d    = d_we;
               m_addr_d  = d_addr;
               m_wdata_d = d_wdata;
            end
         end
         P_BUSY: begin
            if (m_ready) begin
               state_d = P_DONE;
               m_req_d = 1'b0;
               if (!m_we_q) begin
                  p_rdata_d = m_rdata;
               end
            end
         end
         D_BUSY: begin
            if (m_ready) begin
               state_d = D_DONE;
               m_req_d = 1'b0;
               d_ack_d = 1'b1;
               if (!m_we_q) begin
                  d_rdata_d = m_rdata;
               end
            end
         end
         P_DONE, D_DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            m_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset abandons any transaction in flight
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         m_req_q   <= 1'b0;
         m_we_q    <= 1'b0;
         m_addr_q  <= '0;
         m_wdata_q <= '0;
         p_rdata_q <= '0;
         d_rdata_q <= '0;
         d_ack_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         m_req_q   <= m_req_d;
         m_we_q    <= m_we_d;
         m_addr_q  <= m_addr_d;
         m_wdata_q <= m_wdata_d;
         p_rdata_q <= p_rdata_d;
         d_rdata_q <= d_rdata_d;
         d_ack_q   <= d_ack_d;
      end
   end

   // Pipeline freeze: released in the single cycle the P result is available
   assign stall = p_pend && (state_q != P_DONE) && !reset;

   assign m_req   = m_req_q;
   assign m_we    = m_we_q;
   assign m_addr  = m_addr_q;
   assign m_wdata = m_wdata_q;
   assign p_rdata = p_rdata_q;
   assign d_rdata = d_rdata_q;
   assign d_ack   = d_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a transaction-level
// reference model compared every cycle, plus hand-computed scenario checks.
// Build with +define+DMEM_ARB_FAIR_EN to check the alternating-grant variant.
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset, p_read, p_write, d_req, d_we;
   logic [31:0] p_addr, p_wdata, d_addr, d_wdata, m_rdata;
   logic [31:0] p_rdata, d_rdata, m_addr, m_wdata;
   logic        stall, d_ack, m_req, m_we, m_ready;

   int lat = 0;
   int wait_cnt = 0;
   int n_tests = 0;
   int n_fail = 0;
   int stall_cyc = 0, mreq_cyc = 0, mwe_cyc = 0, dack_cyc = 0;
   logic [31:0] glog [$];
   bit   mon_en = 1'b0;
   logic prev_req = 1'b0;

   dmem_arbiter dut (
      .clk(clk), .reset(reset),
      .p_read(p_read), .p_write(p_write), .p_addr(p_addr), .p_wdata(p_wdata),
      .p_rdata(p_rdata), .stall(stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready)
   );

   // Memory responder: ready after 'lat' low cycles of each request
   assign m_ready = (wait_cnt >= lat);
   always @(posedge clk) wait_cnt <= (m_req && !m_ready) ? wait_cnt + 1 : 0;

   // Reference model: one outstanding transaction plus a one-cycle completion marker
   logic        mv_act, mv_is_d, mv_we, mv_fin_p, mv_fin_d, mv_last_d, mv_take_d;
   logic [31:0] mv_addr, mv_wdata, mv_prd, mv_drd;

   assign mv_take_d = d_req && (!(p_read | p_write) || (FAIR && !mv_last_d));

   always @(posedge clk) begin
      if (reset) begin
         mv_act <= 1'b0; mv_is_d <= 1'b0; mv_we <= 1'b0;
         mv_fin_p <= 1'b0; mv_fin_d <= 1'b0; mv_last_d <= 1'b1;
         mv_addr <= '0; mv_wdata <= '0; mv_prd <= '0; mv_drd <= '0;
      end else if (mv_fin_p || mv_fin_d) begin
         mv_fin_p <= 1'b0;
         mv_fin_d <= 1'b0;
      end else if (mv_act) begin
         if (m_ready) begin
            mv_act <= 1'b0;
            if (mv_is_d) begin
               mv_fin_d <= 1'b1;
               if (!mv_we) mv_drd <= m_rdata;
            end else begin
               mv_fin_p <= 1'b1;
               if (!mv_we) mv_prd <= m_rdata;
            end
         end
      end else if ((p_read | p_write) || d_req) begin
         mv_act    <= 1'b1;
         mv_is_d   <= mv_take_d;
         mv_last_d <= mv_take_d;
         mv_we     <= mv_take_d ? d_we    : p_write;
         mv_addr   <= mv_take_d ? d_addr  : p_addr;
         mv_wdata  <= mv_take_d ? d_wdata : p_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare against the model, plus activity counters
   initial begin
      forever begin
         @(negedge clk);
         if (mon_en) begin
            chk("m_req",   32'(m_req), 32'(mv_act));
            chk("d_ack",   32'(d_ack), 32'(mv_fin_d));
            chk("stall",   32'(stall), 32'((p_read | p_write) && !mv_fin_p && !reset));
            chk("m_we",    32'(m_we),  32'(mv_we));
            chk("m_addr",  m_addr,  mv_addr);
            chk("m_wdata", m_wdata, mv_wdata);
            chk("p_rdata", p_rdata, mv_prd);
            chk("d_rdata", d_rdata, mv_drd);
            if (stall) stall_cyc++;
            if (m_req) mreq_cyc++;
            if (m_req && m_we) mwe_cyc++;
            if (d_ack) dack_cyc++;
            if (m_req && !prev_req) glog.push_back(m_addr);
            prev_req = m_req;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      stall_cyc = 0; mreq_cyc = 0; mwe_cyc = 0; dack_cyc = 0;
      glog.delete();
   endtask

   // One P access: hold the request until the stall drops, then release it
   task automatic p_txn(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, output int st);
      bit done = 1'b0;
      p_read = rd; p_write = wr; p_addr = a; p_wdata = wd; st = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            break;
         end
         st++;
      end
      chk("p_txn_done", 32'(done), 32'd1);
      tick();
      p_read = 1'b0; p_write = 1'b0;
   endtask

   // One D access: hold d_req until the ack pulse is seen
   task automatic d_txn(input logic we, input logic [31:0] a, input logic [31:0] wd);
      bit done = 1'b0;
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (d_ack) begin
            done = 1'b1;
            break;
         end
      end
      chk("d_txn_done", 32'(done), 32'd1);
      tick();
      d_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, expected finish before timeout");
      $fatal(1);
   end

   initial begin
      int st, st2;
      logic [31:0] exp_e [4];

      reset = 1'b1; p_read = 1'b0; p_write = 1'b0; p_addr = '0; p_wdata = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; m_rdata = '0;
      @(posedge clk); #1;
      mon_en = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_m_req", 32'(m_req), 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      chk("rst_p_rdata", p_rdata, 32'd0);
      tick();

      // Load, memory always ready
      clr(); lat = 0; m_rdata = 32'h0000_ABCD;
      p_txn(1'b1, 1'b0, 32'h10, 32'h0, st);
      chk("A_stall_cycles", 32'(st), 32'd2);
      chk("A_mreq_cycles", 32'(mreq_cyc), 32'd1);
      chk("A_addr", (glog.size() > 0) ? glog[0] : 32'hxxxx_xxxx, 32'h10);
      chk("A_p_rdata", p_rdata, 32'h0000_ABCD);

      // Store with three not-ready busy cycles
      clr(); lat = 3;
      p_txn(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, st);
      chk("B_stall_cycles", 32'(st), 32'd5);
      chk("B_mreq_cycles", 32'(mreq_cyc), 32'd4);
      chk("B_mwe_cycles", 32'(mwe_cyc), 32'd4);
      chk("B_p_rdata_kept", p_rdata, 32'h0000_ABCD);

      // Read and write together: performed as a write, read data untouched
      clr(); lat = 1; m_rdata = 32'h5555_5555;
      p_txn(1'b1, 1'b1, 32'h30, 32'h1234_5678, st);
      chk("C_stall_cycles", 32'(st), 32'd3);
      chk("C_mwe_cycles", 32'(mwe_cyc), 32'd2);
      chk("C_p_rdata_kept", p_rdata, 32'h0000_ABCD);

      // D request one cycle ahead of a P load: D first, P stalls through it
      clr(); lat = 1; m_rdata = 32'hCAFE_0001;
      fork
         d_txn(1'b0, 32'h200, 32'h0);
         begin
            tick();
            p_txn(1'b1, 1'b0, 32'h100, 32'h0, st);
         end
      join
      chk("D_stall_cycles", 32'(st), 32'd6);
      chk("D_ack_pulses", 32'(dack_cyc), 32'd1);
      chk("D_first", (glog.size() > 0) ? glog[0] : 32'hxxxx_xxxx, 32'h200);
      chk("D_second", (glog.size() > 1) ? glog[1] : 32'hxxxx_xxxx, 32'h100);
      chk("D_d_rdata", d_rdata, 32'hCAFE_0001);
      chk("D_p_rdata", p_rdata, 32'hCAFE_0001);

      // Back-to-back simultaneous P and D traffic from a fresh reset
      reset = 1'b1; tick(); reset = 1'b0;
      clr(); lat = 0; m_rdata = 32'h0000_00E0;
      if (FAIR) begin
         exp_e[0] = 32'h100; exp_e[1] = 32'h200; exp_e[2] = 32'h104; exp_e[3] = 32'h204;
      end else begin
         exp_e[0] = 32'h100; exp_e[1] = 32'h104; exp_e[2] = 32'h200; exp_e[3] = 32'h204;
      end
      fork
         begin
            p_txn(1'b1, 1'b0, 32'h100, 32'h0, st);
            p_txn(1'b1, 1'b0, 32'h104, 32'h0, st2);
         end
         begin
            d_txn(1'b1, 32'h200, 32'hD0D0_0000);
            d_txn(1'b1, 32'h204, 32'hD0D0_0004);
         end
      join
      repeat (4) tick();
      chk("E_grants", 32'(glog.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("E_grant%0d", i), (i < glog.size()) ? glog[i] : 32'hxxxx_xxxx, exp_e[i]);
      end
      chk("E_ack_pulses", 32'(dack_cyc), 32'd2);
      chk("E_d_rdata_zero", d_rdata, 32'h0);

      // Reset while a P load is waiting on memory
      clr(); lat = 5; m_rdata = 32'h7777_7777;
      p_read = 1'b1; p_addr = 32'h40;
      tick();
      reset = 1'b1;
      @(negedge clk);
      chk("F_stall_in_reset", 32'(stall), 32'd0);
      chk("F_busy_before_edge", 32'(m_req), 32'd1);
      tick();
      @(negedge clk);
      chk("F_m_req", 32'(m_req), 32'd0);
      chk("F_m_addr", m_addr, 32'd0);
      chk("F_m_we", 32'(m_we), 32'd0);
      chk("F_p_rdata", p_rdata, 32'd0);
      chk("F_d_ack", 32'(d_ack), 32'd0);
      tick();
      reset = 1'b0; p_read = 1'b0;
      repeat (3) tick();
      chk("F_no_ack", 32'(dack_cyc), 32'd0);
      chk("F_p_rdata_after", p_rdata, 32'd0);

      mon_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Ports (name / direction / width / meaning) SHALL be:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- p_read  in  1  MEM-stage load request (MemReadMEM)
- p_write  in  1  MEM-stage store request (MemWriteMEM)
- p_addr  in  32  MEM-stage address (ALUresultMEM)
- p_wdata  in  32  MEM-stage store data (dmemdata)
- p_rdata  out  32  load data returned to MEM stage
- stall  out  1  freeze EX/MEM and earlier pipeline registers
- d_req  in  1  debug/DMA port request, held until d_ack
- d_we  in  1  debug port write enable
- d_addr  in  32  debug port address
- d_wdata  in  32  debug port write data
- d_rdata  out  32  debug port read data
- d_ack  out  1  debug transaction complete, one-cycle pulse
- m_req  out  1  data-memory request
- m_we  out  1  data-memory write enable
- m_addr  out  32  data-memory address
- m_wdata  out  32  data-memory write data
- m_rdata  in  32  data-memory read data
- m_ready  in  1  data-memory completion, sampled only while m_req=1

Function
REQ-003 The FSM SHALL have states IDLE, P_BUSY, P_DONE, D_BUSY, D_DONE.
REQ-004 In IDLE, a pending P request (p_read|p_write) SHALL move to P_BUSY; a pending d_req SHALL move to D_BUSY; with both pending, P wins (see REQ-016).
REQ-005 On each grant, m_addr/m_wdata/m_we SHALL be registered from the granted port; m_we=p_write for P, d_we for D.
REQ-006 If p_read and p_write are both high, the access SHALL be a write and p_rdata SHALL be left unchanged.
REQ-007 m_req SHALL be 1 exactly in P_BUSY and D_BUSY; m_addr, m_wdata and m_we SHALL hold stable while m_req=1.
REQ-008 P_BUSY or D_BUSY SHALL remain until m_ready=1, then go to P_DONE or D_DONE; there is no timeout.
REQ-009 On P completion, p_rdata SHALL capture m_rdata for reads; on D completion, d_rdata SHALL capture m_rdata when d_we=0.
REQ-010 stall SHALL equal (p_read|p_write) AND state≠P_DONE AND reset=0 (combinational); it is therefore high in the first request cycle.
REQ-011 P_DONE and D_DONE SHALL last exactly one cycle, then go to IDLE; requests SHALL NOT be sampled in these states.
REQ-012 d_ack SHALL be 1 only in D_DONE.
REQ-013 A P request arriving while D is busy SHALL stall until D_DONE→IDLE and then be granted.
REQ-014 Minimum P latency: request cycle (IDLE), P_BUSY with m_ready=1, then P_DONE with stall=0, i.e. 2 stall cycles. Each extra m_ready-low cycle SHALL add one stall cycle.

Reset
REQ-015 When reset=1 at a clock edge, state SHALL become IDLE and m_req, m_we, m_addr, m_wdata, p_rdata, d_rdata and d_ack SHALL become 0. A transaction in flight SHALL be abandoned with no ack. stall SHALL be 0 while reset=1.

Configuration
REQ-016 Macro DMEM_ARB_FAIR_EN: when undefined, P SHALL have fixed priority. When defined, a last_grant flag (reset value: D) SHALL record the last grant, and on a simultaneous request in IDLE the port not granted last SHALL win.

Verification
REQ-017 Load with m_ready tied to 1, p_read=1, p_addr=0x10, m_rdata=0x0000ABCD → stall=1 for 2 cycles, m_req=1 for 1 cycle with m_addr=0x10, then p_rdata=0x0000ABCD and stall=0.
REQ-018 Store p_write=1, p_addr=0x20, p_wdata=0xDEADBEEF, with m_ready low for 3 busy cycles → m_we=1, m_wdata=0xDEADBEEF stable for 4 m_req cycles, stall high for 5 cycles.
REQ-019 d_req raised one cycle before p_read → D served first with one d_ack pulse; P stalls through D_BUSY and D_DONE, then is granted.
REQ-020 d_req and p_read raised together on repeated back-to-back transactions → without DMEM_ARB_FAIR_EN, P is always granted first; with it defined, the grant order is P, D, P, D.
REQ-021 reset asserted during P_BUSY → next cycle state IDLE, m_req=0, all registered outputs 0, no d_ack, stall=0 while reset=1.
REQ-022 p_read=p_write=1 → write performed (m_we=1) and p_rdata unchanged.
